// File: rtl/score4_pkg.sv
// Shared Score-4 types and helpers: board geometry, cell encoding, controller states,
// and one-hot column decoding used by the move controller.
package score4_pkg;

    localparam int COLS      = 7;
    localparam int ROWS      = 6;
    localparam int MAX_MOVES = COLS * ROWS;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P1    = 2'b01,
        P2    = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WRITE,
        REJECT
    } state_t;

    function automatic logic [2:0] onehot_to_idx(input logic [COLS-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < COLS; i++) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    function automatic logic is_onehot(input logic [COLS-1:0] v);
        return (v != '0) && ((v & (v - COLS'(1))) == '0);
    endfunction

endpackage

// File: rtl/move_controller.sv
// Score-4 game-state owner: holds the board, whose turn it is and the move count, and
// turns a one-hot column request into either a committed disc or a rejection pulse.
module move_controller
    import score4_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             new_game,
    input  logic [COLS-1:0]                  play,
    input  logic                             commit,
    input  logic [3:0]                       free,
    input  logic                             valid,
    output logic [COLS-1:0][ROWS-1:0][1:0]   panel,
    output logic [COLS-1:0]                  play_q,
    output logic                             turn,
    output logic                             busy,
    output logic                             move_ok,
    output logic                             move_err,
    output logic [5:0]                       moves,
    output logic                             board_full
);

    state_t                           state_q, state_d;
    logic [COLS-1:0][ROWS-1:0][1:0]   panel_q;
    logic                             turn_q;
    logic [5:0]                       moves_q;
    logic                             full_q;
    logic [2:0]                       row_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (commit) begin
                    state_d = full_q ? REJECT : CHECK;
                end
            end
            CHECK: begin
                if (!is_onehot(play_q) || !valid || (free >= 4'(ROWS))) begin
                    state_d = REJECT;
                end else begin
                    state_d = WRITE;
                end
            end
            WRITE:   state_d = IDLE;
            REJECT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (new_game) begin
            state_d = IDLE;
        end
    end

    // new_game discards the WRITE, so its pulse is suppressed in that cycle too.
    assign busy       = (state_q != IDLE);
    assign move_ok    = (state_q == WRITE) && !new_game;
    assign move_err   = (state_q == REJECT) && !new_game;
    assign panel      = panel_q;
    assign turn       = turn_q;
    assign moves      = moves_q;
    assign board_full = full_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            panel_q <= '0;
            play_q  <= '0;
            turn_q  <= 1'b0;
            moves_q <= 6'd0;
            full_q  <= 1'b0;
            row_q   <= 3'd0;
        end else if (new_game) begin
            state_q <= IDLE;
            panel_q <= '0;
            play_q  <= '0;
            turn_q  <= 1'b0;
            moves_q <= 6'd0;
            full_q  <= 1'b0;
            row_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && commit && !full_q) begin
                play_q <= play;
            end
            // free is only trusted in CHECK, so the row is held for the WRITE cycle.
            if (state_q == CHECK) begin
                row_q <= free[2:0];
            end
            if (state_q == WRITE) begin
                panel_q[onehot_to_idx(play_q)][row_q] <= turn_q ? P2 : P1;
                turn_q <= ~turn_q;
                if (moves_q != 6'(MAX_MOVES)) begin
                    moves_q <= moves_q + 6'd1;
                end
                full_q <= (moves_q >= 6'(MAX_MOVES - 1));
            end
        end
    end

endmodule
